// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the divided-clock controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_e;

  // Smallest legal half-period; a requested value of zero is raised to this.
  localparam int CLAMP_MIN = 1;

  // Half-period, in input clock cycles, that yields f_out from f_in.
  function automatic int default_half(input int f_in, input int f_out);
    return f_in / (2 * f_out);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and output toggle flop. Counts while count_en is high,
// otherwise holds the output low with the counter cleared. cur_half can be
// reloaded synchronously; fall_boundary flags the cycle whose closing edge
// takes clk_out from 1 to 0.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] RESET_HALF = CNT_W'(2)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             count_en,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_half,
  output logic             clk_out,
  output logic             tick,
  output logic             fall_boundary,
  output logic [CNT_W-1:0] cur_half
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_half_q, cur_half_d;
  logic [CNT_W-1:0] half_m1;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             at_end;

  assign half_m1       = cur_half_q - CNT_W'(1);
  assign at_end        = (cnt_q == half_m1);
  assign fall_boundary = count_en && at_end && clk_out_q;

  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign cur_half = cur_half_q;

  // Next counter/output values: wrap and toggle at the end of each half period.
  always_comb begin
    cnt_d      = cnt_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    cur_half_d = cur_half_q;
    if (count_en) begin
      if (at_end) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = ~clk_out_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end
    if (load_en) begin
      cur_half_d = load_half;
    end
  end

  // Counter, output, tick and half-period registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      cur_half_q <= RESET_HALF;
    end else begin
      cnt_q      <= cnt_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      cur_half_q <= cur_half_d;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free divided clock controller: sequences start, stop and ratio
// changes so that a new half-period only lands on a falling boundary of
// clk_out. Consumers should use tick as a clock enable on clk_in.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int F_IN  = 100,
  parameter int F_OUT = 25,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] cur_half
);

  localparam logic [CNT_W-1:0] RESET_HALF = CNT_W'(default_half(F_IN, F_OUT));
  localparam logic [CNT_W-1:0] HALF_MIN   = CNT_W'(CLAMP_MIN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] cfg_clamped;
  logic [CNT_W-1:0] load_half;
  logic             load_en;
  logic             xfer;
  logic             fall_boundary;

  assign cfg_clamped = (cfg_half == '0) ? HALF_MIN : cfg_half;
  assign cfg_ready   = (state_q != SWITCH);
  assign xfer        = cfg_valid && cfg_ready;
  assign running     = (state_q != STOP);

  clk_div_core #(
    .CNT_W      (CNT_W),
    .RESET_HALF (RESET_HALF)
  ) u_core (
    .clk_in        (clk_in),
    .reset         (reset),
    .count_en      (running),
    .load_en       (load_en),
    .load_half     (load_half),
    .clk_out       (clk_out),
    .tick          (tick),
    .fall_boundary (fall_boundary),
    .cur_half      (cur_half)
  );

  // Next state, pending capture and half-period load requests.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    load_en   = 1'b0;
    load_half = cfg_clamped;
    case (state_q)
      STOP: begin
        if (xfer) begin
          load_en = 1'b1;
        end
        if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          pending_d = cfg_clamped;
          state_d   = SWITCH;
        end else if (fall_boundary && !enable) begin
          state_d = STOP;
        end
      end
      SWITCH: begin
        if (fall_boundary) begin
          load_en   = 1'b1;
          load_half = pending_q;
          state_d   = enable ? RUN : STOP;
        end
      end
      default: begin
        state_d = STOP;
      end
    endcase
  end

  // State and pending half-period registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= STOP;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: a period-position reference model is
// compared against the outputs after every clock edge, and directed scenarios
// pin the model with hand-computed phase lengths and tick spacings.
module tb_clk_div_ctrl;

  localparam int CNT_W = 16;

  logic             clk_in    = 1'b0;
  logic             reset     = 1'b1;
  logic             enable    = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_half  = '0;
  logic             cfg_ready;
  logic             clk_out;
  logic             tick;
  logic             running;
  logic [CNT_W-1:0] cur_half;

  int errors = 0;
  int checks = 0;

  // Reference model: position inside the current output period (low phase
  // first), the half-period in effect and any half-period awaiting a boundary.
  int m_mode;
  int m_half;
  int m_pend;
  int m_pos;
  bit m_clk;
  bit m_tick;

  clk_div_ctrl #(
    .F_IN  (100),
    .F_OUT (25),
    .CNT_W (CNT_W)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .running   (running),
    .cur_half  (cur_half)
  );

  // 100 MHz input clock.
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_mode = 0;
    m_half = 2;
    m_pend = 0;
    m_pos  = 0;
    m_clk  = 1'b0;
    m_tick = 1'b0;
  endtask

  task automatic modelStep();
    bit ready;
    bit xfer;
    bit boundary;
    bit prev;
    int clamped;
    ready    = (m_mode != 2);
    xfer     = cfg_valid && ready;
    clamped  = (cfg_half == '0) ? 1 : int'(cfg_half);
    boundary = (m_mode != 0) && (m_pos == 2 * m_half - 1);
    prev     = m_clk;
    case (m_mode)
      0: begin
        if (xfer) m_half = clamped;
        if (enable) m_mode = 1;
        m_pos = 0;
      end
      1: begin
        m_pos = boundary ? 0 : m_pos + 1;
        if (xfer) begin
          m_pend = clamped;
          m_mode = 2;
        end else if (boundary && !enable) begin
          m_mode = 0;
        end
      end
      default: begin
        m_pos = boundary ? 0 : m_pos + 1;
        if (boundary) begin
          m_half = m_pend;
          m_mode = enable ? 1 : 0;
        end
      end
    endcase
    m_clk  = (m_pos >= m_half);
    m_tick = !prev && m_clk;
  endtask

  // Advance the model on each clock edge, or immediately on reset.
  initial begin
    modelReset();
    forever begin
      @(posedge clk_in or posedge reset);
      if (reset) modelReset();
      else modelStep();
    end
  end

  // Compare every output against the model shortly after each clock edge.
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      checkOutput("model_clk_out", clk_out, m_clk);
      checkOutput("model_tick", tick, m_tick);
      checkOutput("model_cur_half", cur_half, m_half);
      checkOutput("model_running", running, m_mode != 0);
      checkOutput("model_cfg_ready", cfg_ready, m_mode != 2);
    end
  end

  task automatic applyStimulus(input logic en, input logic valid, input logic [CNT_W-1:0] half);
    @(negedge clk_in);
    enable    = en;
    cfg_valid = valid;
    cfg_half  = half;
  endtask

  task automatic pulseConfig(input logic en, input logic [CNT_W-1:0] half);
    applyStimulus(en, 1'b1, half);
    applyStimulus(en, 1'b0, half);
  endtask

  task automatic waitTick(input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk_in);
      #1;
      n++;
      if (tick === 1'b1) return;
    end
    checkOutput("tick_timeout", 0, 1);
    n = -1;
  endtask

  task automatic measureRun(input logic level, input int limit, output int n);
    n = 1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk_in);
      #1;
      if (clk_out !== level) return;
      n++;
    end
    checkOutput("run_timeout", 0, 1);
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(posedge clk_in);
      #1;
      if (running === 1'b0) return;
    end
    checkOutput("idle_timeout", 0, 1);
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int n;
    int ticks_seen;
    int highs_seen;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    #1;
    checkOutput("rst_clk_out", clk_out, 0);
    checkOutput("rst_tick", tick, 0);
    checkOutput("rst_cur_half", cur_half, 2);
    checkOutput("rst_cfg_ready", cfg_ready, 1);
    checkOutput("rst_running", running, 0);

    $display("[TB] default ratio start");
    applyStimulus(1'b1, 1'b0, '0);
    waitTick(10, n);
    checkOutput("t1_first_tick_edges", n, 3);
    checkOutput("t1_running", running, 1);
    waitTick(10, n);
    checkOutput("t1_tick_period", n, 4);
    measureRun(1'b1, 10, n);
    checkOutput("t1_high_len", n, 2);
    measureRun(1'b0, 10, n);
    checkOutput("t1_low_len", n, 2);

    $display("[TB] switch 2 -> 3 during high phase");
    checkOutput("t3_at_tick", tick, 1);
    applyStimulus(1'b1, 1'b1, 16'd3);
    applyStimulus(1'b1, 1'b0, 16'd3);
    checkOutput("t3_ready_low", cfg_ready, 0);
    checkOutput("t3_old_half", cur_half, 2);
    checkOutput("t3_still_high", clk_out, 1);
    @(posedge clk_in);
    #1;
    checkOutput("t3_fell_after_2", clk_out, 0);
    checkOutput("t3_new_half", cur_half, 3);
    checkOutput("t3_ready_back", cfg_ready, 1);
    measureRun(1'b0, 10, n);
    checkOutput("t3_low_len", n, 3);
    measureRun(1'b1, 10, n);
    checkOutput("t3_high_len", n, 3);
    applyStimulus(1'b0, 1'b0, '0);
    waitIdle(20);
    checkOutput("t3_stopped_low", clk_out, 0);

    $display("[TB] load 5 while stopped, then start");
    pulseConfig(1'b0, 16'd5);
    checkOutput("t2_loaded", cur_half, 5);
    checkOutput("t2_idle", running, 0);
    applyStimulus(1'b1, 1'b0, '0);
    waitTick(20, n);
    checkOutput("t2_first_tick_edges", n, 6);
    waitTick(20, n);
    checkOutput("t2_tick_period", n, 10);
    applyStimulus(1'b0, 1'b0, '0);
    waitIdle(30);

    $display("[TB] load 4 with enable, stop after a tick");
    pulseConfig(1'b1, 16'd4);
    checkOutput("t4_half", cur_half, 4);
    waitTick(10, n);
    checkOutput("t4_first_tick_edges", n, 4);
    applyStimulus(1'b0, 1'b0, '0);
    measureRun(1'b1, 10, n);
    checkOutput("t4_high_len", n, 4);
    checkOutput("t4_stopped", running, 0);
    ticks_seen = 0;
    highs_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_in);
      #1;
      if (tick !== 1'b0) ticks_seen++;
      if (clk_out !== 1'b0) highs_seen++;
    end
    checkOutput("t4_no_tick_in_stop", ticks_seen, 0);
    checkOutput("t4_low_in_stop", highs_seen, 0);

    $display("[TB] zero half-period clamps to one");
    pulseConfig(1'b1, '0);
    checkOutput("t5_clamped", cur_half, 1);
    waitTick(10, n);
    checkOutput("t5_first_tick_edges", n, 1);
    waitTick(10, n);
    checkOutput("t5_tick_period", n, 2);
    measureRun(1'b1, 10, n);
    checkOutput("t5_high_len", n, 1);

    $display("[TB] reset during a pending switch");
    pulseConfig(1'b1, 16'd7);
    checkOutput("t6_in_switch", cfg_ready, 0);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_clk_out", clk_out, 0);
    checkOutput("t6_rst_tick", tick, 0);
    checkOutput("t6_rst_cur_half", cur_half, 2);
    checkOutput("t6_rst_cfg_ready", cfg_ready, 1);
    checkOutput("t6_rst_running", running, 0);
    @(negedge clk_in);
    reset = 1'b0;
    waitTick(10, n);
    checkOutput("t6_first_tick_edges", n, 3);
    waitTick(10, n);
    checkOutput("t6_tick_period", n, 4);
    checkOutput("t6_half_kept", cur_half, 2);

    applyStimulus(1'b0, 1'b0, '0);
    repeat (2) @(posedge clk_in);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
